nv_nvdla_dmaif_rd_route_ctrl: RTL and testbench



---
 rtl/nv_nvdla_dmaif_rd_route_ctrl_pkg.sv | 38 +++
 rtl/nv_nvdla_dmaif_outs_cnt.sv | 40 ++++
 rtl/nv_nvdla_dmaif_rd_route_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_nv_nvdla_dmaif_rd_route_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_dmaif_rd_route_ctrl_pkg.sv
// Shared definitions for the DMA read-request route controller.
package nv_nvdla_dmaif_rd_route_ctrl_pkg;

  // Route ownership states. Values are fixed so debug taps decode stably.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MC    = 3'd1,
    ST_CV    = 3'd2,
    ST_SW_MC = 3'd3,
    ST_SW_CV = 3'd4
  } route_state_e;

  // Encoding of dmaif_rd_req_ram_type.
  localparam logic RAM_TYPE_MC = 1'b1;
  localparam logic RAM_TYPE_CV = 1'b0;

  // Default payload geometry.
  localparam int DEF_ADDR_W = 64;
  localparam int DEF_SIZE_W = 8;

  // Payload is {size, addr} with size in the MSBs.
  function automatic int addr_lsb();
    return 0;
  endfunction

  function automatic int addr_msb(input int addr_w);
    return addr_w - 1;
  endfunction

  function automatic int size_lsb(input int addr_w);
    return addr_w;
  endfunction

  function automatic int size_msb(input int addr_w, input int size_w);
    return addr_w + size_w - 1;
  endfunction

endpackage

// File: rtl/nv_nvdla_dmaif_outs_cnt.sv
// Outstanding response-beat counter for one memory interface.
// Adds the beat count of an accepted request and removes one per returned
// beat. A beat against an empty counter is dropped and flagged as underflow.
module nv_nvdla_dmaif_outs_cnt #(
  parameter int CNT_W         = 9,
  parameter int MAX_OUT_BEATS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             add_en,
  input  logic [CNT_W-1:0] add_val,
  input  logic             beat,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             beat_eff;

  // Net add and beat in one step; an underflowing beat does not decrement.
  always_comb begin
    underflow = beat && (cnt_q == '0);
    beat_eff  = beat && (cnt_q != '0);
    cnt_d     = cnt_q + (add_en ? add_val : '0) - {{(CNT_W-1){1'b0}}, beat_eff};
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

  // Credit gating upstream makes this unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    ({1'b0, cnt_q} <= (CNT_W+1)'(MAX_OUT_BEATS)));

endmodule

// File: rtl/nv_nvdla_dmaif_rd_route_ctrl.sv
// DMA read-request router: steers requests to MCIF or CVIF, never lets both
// interfaces have responses outstanding together, and caps outstanding beats.
//
// Handshake: every request channel here uses valid/ready. A transfer happens
// on a rising clock edge where valid and ready are both high. Once valid is
// raised it stays high, with payload unchanged, until that transfer. Ready may
// be computed without looking at valid.
module nv_nvdla_dmaif_rd_route_ctrl
  import nv_nvdla_dmaif_rd_route_ctrl_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int SIZE_W        = DEF_SIZE_W,
  parameter int MAX_OUT_BEATS = 256,
  parameter int CNT_W         = 9
) (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rst,
  input  logic                     dmaif_rd_req_pvld,
  output logic                     dmaif_rd_req_prdy,
  input  logic [ADDR_W+SIZE_W-1:0] dmaif_rd_req_pd,
  input  logic                     dmaif_rd_req_ram_type,
  output logic                     mcif_rd_req_valid,
  input  logic                     mcif_rd_req_ready,
  output logic [ADDR_W+SIZE_W-1:0] mcif_rd_req_pd,
  output logic                     cvif_rd_req_valid,
  input  logic                     cvif_rd_req_ready,
  output logic [ADDR_W+SIZE_W-1:0] cvif_rd_req_pd,
  input  logic                     mcif_rsp_beat,
  input  logic                     cvif_rsp_beat,
  output logic [CNT_W-1:0]         mc_outs_cnt,
  output logic [CNT_W-1:0]         cv_outs_cnt,
  output logic                     rsp_err,
  output logic                     ctrl_idle,
  output logic [2:0]               dbg_state
);

  localparam int PD_W     = ADDR_W + SIZE_W;
  localparam int SIZE_MSB = size_msb(ADDR_W, SIZE_W);
  localparam int SIZE_LSB = size_lsb(ADDR_W);
  localparam logic [CNT_W:0] MAX_BEATS = (CNT_W+1)'(MAX_OUT_BEATS);

  route_state_e state_q, state_d;

  logic            mc_vld_q, mc_vld_d;
  logic [PD_W-1:0] mc_pd_q,  mc_pd_d;
  logic            cv_vld_q, cv_vld_d;
  logic [PD_W-1:0] cv_pd_q,  cv_pd_d;
  logic            err_q,    err_d;

  logic [SIZE_W-1:0] req_size;
  logic [CNT_W-1:0]  req_beats;
  logic              tgt_mc;
  logic              owner_ok;
  logic              mc_credit_ok, cv_credit_ok;
  logic              mc_free, cv_free;
  logic              grant_ok;
  logic              accept;
  logic              mc_add, cv_add;
  logic              mc_uf, cv_uf;
  logic [CNT_W-1:0]  mc_cnt, cv_cnt;
  logic [CNT_W:0]    mc_proj, cv_proj;

  assign req_size  = dmaif_rd_req_pd[SIZE_MSB:SIZE_LSB];
  assign req_beats = CNT_W'(req_size) + CNT_W'(1);
  assign tgt_mc    = (dmaif_rd_req_ram_type == RAM_TYPE_MC);

  // Grant: owner match, beat credit (a beat this cycle frees credit at once),
  // and room in the target output register.
  always_comb begin
    mc_proj = {1'b0, mc_cnt} + {1'b0, req_beats}
              - {{CNT_W{1'b0}}, (mcif_rsp_beat && (mc_cnt != '0))};
    cv_proj = {1'b0, cv_cnt} + {1'b0, req_beats}
              - {{CNT_W{1'b0}}, (cvif_rsp_beat && (cv_cnt != '0))};
    mc_credit_ok = (mc_proj <= MAX_BEATS);
    cv_credit_ok = (cv_proj <= MAX_BEATS);
    mc_free      = !mc_vld_q || mcif_rd_req_ready;
    cv_free      = !cv_vld_q || cvif_rd_req_ready;
    owner_ok     = (state_q == ST_IDLE)
                || ((state_q == ST_MC) &&  tgt_mc)
                || ((state_q == ST_CV) && !tgt_mc);
    grant_ok     = owner_ok && (tgt_mc ? (mc_credit_ok && mc_free)
                                       : (cv_credit_ok && cv_free));
    accept       = dmaif_rd_req_pvld && grant_ok;
    mc_add       = accept &&  tgt_mc;
    cv_add       = accept && !tgt_mc;
  end

  assign dmaif_rd_req_prdy = grant_ok;

  // Ownership FSM: switching waits until the old owner has fully drained.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (dmaif_rd_req_pvld) state_d = tgt_mc ? ST_MC : ST_CV;
      end
      ST_MC: begin
        if (dmaif_rd_req_pvld && !tgt_mc) state_d = ST_SW_CV;
      end
      ST_CV: begin
        if (dmaif_rd_req_pvld && tgt_mc) state_d = ST_SW_MC;
      end
      ST_SW_CV: begin
        if ((mc_cnt == '0) && !mc_vld_q) state_d = ST_CV;
      end
      ST_SW_MC: begin
        if ((cv_cnt == '0) && !cv_vld_q) state_d = ST_MC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output registers: load on accept, drop valid once downstream takes it.
  always_comb begin
    mc_vld_d = mc_vld_q;
    mc_pd_d  = mc_pd_q;
    cv_vld_d = cv_vld_q;
    cv_pd_d  = cv_pd_q;
    if (mc_add) begin
      mc_vld_d = 1'b1;
      mc_pd_d  = dmaif_rd_req_pd;
    end else if (mcif_rd_req_ready) begin
      mc_vld_d = 1'b0;
    end
    if (cv_add) begin
      cv_vld_d = 1'b1;
      cv_pd_d  = dmaif_rd_req_pd;
    end else if (cvif_rd_req_ready) begin
      cv_vld_d = 1'b0;
    end
    err_d = err_q || mc_uf || cv_uf;
  end

  // State and output registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state_q  <= ST_IDLE;
      mc_vld_q <= 1'b0;
      mc_pd_q  <= '0;
      cv_vld_q <= 1'b0;
      cv_pd_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mc_vld_q <= mc_vld_d;
      mc_pd_q  <= mc_pd_d;
      cv_vld_q <= cv_vld_d;
      cv_pd_q  <= cv_pd_d;
      err_q    <= err_d;
    end
  end

  nv_nvdla_dmaif_outs_cnt #(
    .CNT_W         (CNT_W),
    .MAX_OUT_BEATS (MAX_OUT_BEATS)
  ) u_mc_cnt (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .add_en    (mc_add),
    .add_val   (req_beats),
    .beat      (mcif_rsp_beat),
    .cnt       (mc_cnt),
    .underflow (mc_uf)
  );

  nv_nvdla_dmaif_outs_cnt #(
    .CNT_W         (CNT_W),
    .MAX_OUT_BEATS (MAX_OUT_BEATS)
  ) u_cv_cnt (
    .clk       (nvdla_core_clk),
    .rst       (nvdla_core_rst),
    .add_en    (cv_add),
    .add_val   (req_beats),
    .beat      (cvif_rsp_beat),
    .cnt       (cv_cnt),
    .underflow (cv_uf)
  );

  assign mcif_rd_req_valid = mc_vld_q;
  assign mcif_rd_req_pd    = mc_pd_q;
  assign cvif_rd_req_valid = cv_vld_q;
  assign cvif_rd_req_pd    = cv_pd_q;
  assign mc_outs_cnt       = mc_cnt;
  assign cv_outs_cnt       = cv_cnt;
  assign rsp_err           = err_q;
  assign ctrl_idle         = (mc_cnt == '0) && (cv_cnt == '0) && !mc_vld_q && !cv_vld_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_nv_nvdla_dmaif_rd_route_ctrl.sv
// Directed bench for the DMA read-request route controller.
module tb_nv_nvdla_dmaif_rd_route_ctrl;
  import nv_nvdla_dmaif_rd_route_ctrl_pkg::*;

  localparam int ADDR_W = 64;
  localparam int SIZE_W = 8;
  localparam int CNT_W  = 9;
  localparam int PD_W   = ADDR_W + SIZE_W;

  logic              clk;
  logic              rst;
  logic              pvld;
  logic              prdy;
  logic [PD_W-1:0]   req_pd;
  logic              ram_type;
  logic              mc_valid, mc_ready;
  logic [PD_W-1:0]   mc_pd;
  logic              cv_valid, cv_ready;
  logic [PD_W-1:0]   cv_pd;
  logic              mc_beat, cv_beat;
  logic [CNT_W-1:0]  mc_cnt, cv_cnt;
  logic              err;
  logic              idle;
  logic [2:0]        state;

  int n_cmp;
  int n_mis;

  nv_nvdla_dmaif_rd_route_ctrl #(
    .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .MAX_OUT_BEATS(256), .CNT_W(CNT_W)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rst        (rst),
    .dmaif_rd_req_pvld     (pvld),
    .dmaif_rd_req_prdy     (prdy),
    .dmaif_rd_req_pd       (req_pd),
    .dmaif_rd_req_ram_type (ram_type),
    .mcif_rd_req_valid     (mc_valid),
    .mcif_rd_req_ready     (mc_ready),
    .mcif_rd_req_pd        (mc_pd),
    .cvif_rd_req_valid     (cv_valid),
    .cvif_rd_req_ready     (cv_ready),
    .cvif_rd_req_pd        (cv_pd),
    .mcif_rsp_beat         (mc_beat),
    .cvif_rsp_beat         (cv_beat),
    .mc_outs_cnt           (mc_cnt),
    .cv_outs_cnt           (cv_cnt),
    .rsp_err               (err),
    .ctrl_idle             (idle),
    .dbg_state             (state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PD_W-1:0] mk_pd(input logic [7:0] size, input logic [63:0] addr);
    return {size, addr};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled at the negedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_req(input logic rt, input logic [7:0] size, input logic [63:0] addr);
    pvld     = 1'b1;
    ram_type = rt;
    req_pd   = mk_pd(size, addr);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mcv"},  mc_valid, 1'b0);
    chk({tag, "_cvv"},  cv_valid, 1'b0);
    chk({tag, "_mcpd"}, mc_pd, '0);
    chk({tag, "_cvpd"}, cv_pd, '0);
    chk({tag, "_mcc"},  mc_cnt, 9'd0);
    chk({tag, "_cvc"},  cv_cnt, 9'd0);
    chk({tag, "_err"},  err, 1'b0);
    chk({tag, "_idle"}, idle, 1'b1);
    chk({tag, "_st"},   state, ST_IDLE);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    rst = 1'b1; pvld = 1'b0; req_pd = '0; ram_type = 1'b0;
    mc_ready = 1'b1; cv_ready = 1'b1; mc_beat = 1'b0; cv_beat = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // First MCIF request, size 3.
    drive_req(RAM_TYPE_MC, 8'd3, 64'hA000);
    #1 chk("s1_prdy", prdy, 1'b1);
    step();
    pvld = 1'b0;
    chk("s1_vld", mc_valid, 1'b1);
    chk("s1_pd", mc_pd, mk_pd(8'd3, 64'hA000));
    chk("s1_cnt", mc_cnt, 9'd4);
    chk("s1_st", state, ST_MC);
    chk("s1_idle0", idle, 1'b0);
    mc_beat = 1'b1;
    repeat (4) step();
    mc_beat = 1'b0;
    chk("s1_cnt0", mc_cnt, 9'd0);
    chk("s1_idle1", idle, 1'b1);

    // Owner switch MC -> CV with two MCIF beats outstanding.
    drive_req(RAM_TYPE_MC, 8'd1, 64'hB000);
    step();
    chk("s2_mccnt", mc_cnt, 9'd2);
    drive_req(RAM_TYPE_CV, 8'd2, 64'hC000);
    #1 chk("s2_prdy_mc", prdy, 1'b0);
    step();
    chk("s2_st_sw", state, ST_SW_CV);
    chk("s2_mccnt2", mc_cnt, 9'd2);
    mc_beat = 1'b1;
    #1 chk("s2_prdy_sw0", prdy, 1'b0);
    step();
    chk("s2_cnt1", mc_cnt, 9'd1);
    chk("s2_cv0a", cv_cnt, 9'd0);
    step();
    chk("s2_cnt0", mc_cnt, 9'd0);
    chk("s2_st_sw2", state, ST_SW_CV);
    mc_beat = 1'b0;
    #1 chk("s2_prdy_sw1", prdy, 1'b0);
    step();
    chk("s2_st_cv", state, ST_CV);
    #1 chk("s2_prdy_cv", prdy, 1'b1);
    step();
    pvld = 1'b0;
    chk("s2_cvv", cv_valid, 1'b1);
    chk("s2_cvpd", cv_pd, mk_pd(8'd2, 64'hC000));
    chk("s2_cvcnt", cv_cnt, 9'd3);
    chk("s2_mc0", mc_cnt, 9'd0);
    cv_beat = 1'b1;
    repeat (3) step();
    cv_beat = 1'b0;
    chk("s2_cvdrain", cv_cnt, 9'd0);

    // Credit limit: 256 beats outstanding blocks a further request until a beat.
    drive_req(RAM_TYPE_MC, 8'd255, 64'hD000);
    #1 chk("s3_prdy_cv", prdy, 1'b0);
    step();
    chk("s3_st_sw", state, ST_SW_MC);
    step();
    chk("s3_st_mc", state, ST_MC);
    #1 chk("s3_prdy1", prdy, 1'b1);
    step();
    chk("s3_cnt256", mc_cnt, 9'd256);
    drive_req(RAM_TYPE_MC, 8'd0, 64'hD100);
    #1 chk("s3_prdy_full", prdy, 1'b0);
    mc_beat = 1'b1;
    #1 chk("s3_prdy_beat", prdy, 1'b1);
    step();
    pvld = 1'b0;
    chk("s3_cnt_hold", mc_cnt, 9'd256);
    chk("s3_pd", mc_pd, mk_pd(8'd0, 64'hD100));
    repeat (256) step();
    mc_beat = 1'b0;
    chk("s3_drain", mc_cnt, 9'd0);
    chk("s3_err", err, 1'b0);
    chk("s3_idle", idle, 1'b1);

    // Backpressure on MCIF, then full-throughput back-to-back requests.
    mc_ready = 1'b0;
    drive_req(RAM_TYPE_MC, 8'd0, 64'hE000);
    step();
    drive_req(RAM_TYPE_MC, 8'd0, 64'hE100);
    for (int i = 0; i < 5; i++) begin
      chk("s4_bp_vld", mc_valid, 1'b1);
      chk("s4_bp_pd", mc_pd, mk_pd(8'd0, 64'hE000));
      #1 chk("s4_bp_prdy", prdy, 1'b0);
      step();
    end
    mc_ready = 1'b1;
    #1 chk("s4_prdy_rel", prdy, 1'b1);
    step();
    chk("s4_pd_e1", mc_pd, mk_pd(8'd0, 64'hE100));
    drive_req(RAM_TYPE_MC, 8'd0, 64'hE200);
    #1 chk("s4_prdy_b2b1", prdy, 1'b1);
    step();
    chk("s4_pd_e2", mc_pd, mk_pd(8'd0, 64'hE200));
    drive_req(RAM_TYPE_MC, 8'd0, 64'hE300);
    #1 chk("s4_prdy_b2b2", prdy, 1'b1);
    step();
    pvld = 1'b0;
    chk("s4_pd_e3", mc_pd, mk_pd(8'd0, 64'hE300));
    chk("s4_cnt", mc_cnt, 9'd4);
    step();
    chk("s4_vld0", mc_valid, 1'b0);
    mc_beat = 1'b1;
    repeat (4) step();
    mc_beat = 1'b0;
    chk("s4_drain", mc_cnt, 9'd0);

    // Simultaneous add and beat, then underflow.
    drive_req(RAM_TYPE_MC, 8'd2, 64'hF000);
    step();
    chk("s5_cnt3", mc_cnt, 9'd3);
    drive_req(RAM_TYPE_MC, 8'd1, 64'hF100);
    mc_beat = 1'b1;
    step();
    pvld = 1'b0;
    chk("s5_net", mc_cnt, 9'd4);
    repeat (4) step();
    chk("s5_zero", mc_cnt, 9'd0);
    chk("s5_err0", err, 1'b0);
    step();
    mc_beat = 1'b0;
    chk("s5_uf_cnt", mc_cnt, 9'd0);
    chk("s5_err1", err, 1'b1);
    step();
    chk("s5_err_sticky", err, 1'b1);

    // Asynchronous reset mid-transfer.
    mc_ready = 1'b0;
    drive_req(RAM_TYPE_MC, 8'd9, 64'h1_0000);
    step();
    pvld = 1'b0;
    chk("s6_cnt10", mc_cnt, 9'd10);
    chk("s6_vld", mc_valid, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("s6_arst");
    @(negedge clk);
    rst = 1'b0;
    mc_ready = 1'b1;
    @(negedge clk);
    drive_req(RAM_TYPE_MC, 8'd0, 64'h2_0000);
    #1 chk("s6_prdy", prdy, 1'b1);
    step();
    pvld = 1'b0;
    chk("s6_vld2", mc_valid, 1'b1);
    chk("s6_pd2", mc_pd, mk_pd(8'd0, 64'h2_0000));
    chk("s6_cnt1", mc_cnt, 9'd1);
    chk("s6_st", state, ST_MC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
